// File: rtl/aes_pkg.sv
// aes_pkg: key-length encodings, AES size constants, FSM state type and helpers
package aes_pkg;

    typedef enum logic [1:0] {
        KL_128  = 2'd0,
        KL_192  = 2'd1,
        KL_256  = 2'd2,
        KL_RSVD = 2'd3
    } key_len_e;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_e;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;
    localparam logic [5:0] NW_128 = 6'd44;
    localparam logic [5:0] NW_192 = 6'd52;
    localparam logic [5:0] NW_256 = 6'd60;

    function automatic logic [3:0] nk_of(input key_len_e kl);
        return kl == KL_256 ? NK_256 : kl == KL_192 ? NK_192 : NK_128;
    endfunction

    function automatic logic [3:0] nr_of(input key_len_e kl);
        return kl == KL_256 ? NR_256 : kl == KL_192 ? NR_192 : NR_128;
    endfunction

    function automatic logic [5:0] nw_of(input key_len_e kl);
        return kl == KL_256 ? NW_256 : kl == KL_192 ? NW_192 : NW_128;
    endfunction

    function automatic int key_bits_of(input key_len_e kl);
        return 32 * int'(nk_of(kl));
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// aes_key_expand_seq_if: request, round-key read and status bundle of the key expander
interface aes_key_expand_seq_if #(
    parameter int MAX_KEY_BITS = 256
);
    logic                    start;
    logic [1:0]              key_len;
    logic [MAX_KEY_BITS-1:0] key;
    logic                    zeroize;
    logic [3:0]              rk_idx;
    logic [127:0]            rk_out;
    logic                    busy;
    logic                    done;
    logic                    key_valid;
    logic                    err;

    modport master (
        output start, key_len, key, zeroize, rk_idx,
        input  rk_out, busy, done, key_valid, err
    );

    modport slave (
        input  start, key_len, key, zeroize, rk_idx,
        output rk_out, busy, done, key_valid, err
    );
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = SBOX[11'd2047 - {din, 3'b000} -: 8];
endmodule

// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: one-word-per-clock AES key schedule; zeroize honoured only with AES_KEY_ZEROIZE_EN
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
) (
    input logic clk,
    input logic rst_n,
    aes_key_expand_seq_if.slave bus
);
    localparam int MAX_NK = MAX_KEY_BITS / 32;
    localparam int MAX_NW = MAX_KEY_BITS >= 256 ? 60 : MAX_KEY_BITS >= 192 ? 52 : 44;

    state_e      state;
    key_len_e    kl;
    logic [31:0] w [MAX_NW];
    logic [5:0]  widx;
    logic [2:0]  phase;
    logic [7:0]  rcon;
    logic [3:0]  nk, nr;
    logic [5:0]  nw;
    key_len_e    req_kl;
    logic        start_ok;
    logic        zero_req;
    logic [31:0] prev, back, rot, sub_in, sub_out, t, new_w;
    logic [5:0]  base;

`ifdef AES_KEY_ZEROIZE_EN
    assign zero_req = bus.zeroize;
`else
    logic zeroize_unused;
    assign zeroize_unused = bus.zeroize;
    assign zero_req = 1'b0;
`endif

    assign nk       = nk_of(kl);
    assign nr       = nr_of(kl);
    assign nw       = nw_of(kl);
    assign req_kl   = key_len_e'(bus.key_len);
    assign start_ok = req_kl != KL_RSVD && key_bits_of(req_kl) <= MAX_KEY_BITS;

    assign prev   = w[widx - 6'd1];
    assign back   = w[widx - {2'b00, nk}];
    assign rot    = {prev[23:0], prev[31:24]};
    assign sub_in = phase == 3'd0 ? rot : prev;

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (.din(sub_in[8*g +: 8]), .dout(sub_out[8*g +: 8]));
    end

    assign t     = phase == 3'd0 ? sub_out ^ {rcon, 24'h0} :
                   (nk == NK_256 && phase == 3'd4) ? sub_out : prev;
    assign new_w = back ^ t;

    assign base       = {bus.rk_idx, 2'b00};
    assign bus.rk_out = (bus.key_valid && bus.rk_idx <= nr) ?
                        {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]} : 128'h0;

    // control FSM with registered status, word store and round-constant sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            kl            <= KL_128;
            widx          <= 6'd0;
            phase         <= 3'd0;
            rcon          <= 8'h00;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.key_valid <= 1'b0;
            bus.err       <= 1'b0;
            for (int k = 0; k < MAX_NW; k++) w[k] <= 32'h0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            if (zero_req) begin
                state         <= IDLE;
                bus.busy      <= 1'b0;
                bus.key_valid <= 1'b0;
                for (int k = 0; k < MAX_NW; k++) w[k] <= 32'h0;
            end else if (state == IDLE) begin
                if (bus.start && start_ok) begin
                    kl            <= req_kl;
                    widx          <= {2'b00, nk_of(req_kl)};
                    phase         <= 3'd0;
                    rcon          <= 8'h01;
                    bus.key_valid <= 1'b0;
                    bus.busy      <= 1'b1;
                    state         <= EXPAND;
                    for (int k = 0; k < MAX_NK; k++)
                        if (k < int'(nk_of(req_kl))) w[k] <= bus.key[MAX_KEY_BITS-1-32*k -: 32];
                end else if (bus.start) begin
                    bus.err <= 1'b1;
                end
            end else begin
                w[widx] <= new_w;
                widx    <= widx + 6'd1;
                rcon    <= phase == 3'd0 ? xtime(rcon) : rcon;
                phase   <= {1'b0, phase} == nk - 4'd1 ? 3'd0 : phase + 3'd1;
                if (widx == nw - 6'd1) begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.done      <= 1'b1;
                    bus.key_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb_aes_key_expand_seq: directed FIPS-197 vectors, error/ignore/abort cases; zeroize checked per AES_KEY_ZEROIZE_EN
module tb_aes_key_expand_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    aes_key_expand_seq_if #(.MAX_KEY_BITS(256)) bus ();

    aes_key_expand_seq #(.MAX_KEY_BITS(256)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_rk(input string tag, input logic [3:0] idx, input logic [127:0] exp);
        bus.rk_idx = idx;
        #1;
        check(tag, bus.rk_out, exp);
    endtask

    task automatic expand(input string tag, input logic [1:0] kl, input logic [255:0] k,
                          input int exp_edges, input int poke_at);
        int dones;
        int first;
        bus.key_len = kl;
        bus.key     = k;
        bus.rk_idx  = 4'd0;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, " busy"}, 128'(bus.busy), 128'd1);
        check({tag, " kv_clr"}, 128'(bus.key_valid), 128'd0);
        check({tag, " rk_hidden"}, bus.rk_out, 128'h0);
        dones = 0;
        first = 0;
        for (int n = 1; n <= exp_edges + 20; n++) begin
            bus.start = (n == poke_at);
            if (n == poke_at) begin
                bus.key_len = 2'd2;
                bus.key     = ~k;
            end
            tick();
            if (bus.done) begin
                dones++;
                if (first == 0) first = n;
            end
        end
        bus.start = 1'b0;
        check({tag, " done_edge"}, 128'(first), 128'(exp_edges));
        check({tag, " done_count"}, 128'(dones), 128'd1);
        check({tag, " busy_end"}, 128'(bus.busy), 128'd0);
        check({tag, " kv_set"}, 128'(bus.key_valid), 128'd1);
    endtask

    initial begin
        int dones;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.key_len = 2'd0;
        bus.key     = '0;
        bus.zeroize = 1'b0;
        bus.rk_idx  = 4'd0;
        repeat (3) tick();
        check("rst busy", 128'(bus.busy), 128'd0);
        check("rst done", 128'(bus.done), 128'd0);
        check("rst kv", 128'(bus.key_valid), 128'd0);
        check("rst err", 128'(bus.err), 128'd0);
        check("rst rk", bus.rk_out, 128'h0);
        rst_n = 1'b1;
        tick();

        expand("a128", 2'd0, K128, 40, 0);
        read_rk("a128 rk0", 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        read_rk("a128 rk1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk("a128 rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_rk("a128 rk11", 4'd11, 128'h0);

        expand("a192", 2'd1, K192, 46, 0);
        read_rk("a192 rk12", 4'd12, 128'he98ba06f448c773c8ecc720401002202);
        read_rk("a192 rk13", 4'd13, 128'h0);

        expand("a256", 2'd2, K256, 52, 0);
        bus.rk_idx = 4'd14;
        #1;
        check("a256 rk14 low", 128'(bus.rk_out[31:0]), 128'h706c631e);
        read_rk("a256 rk1", 4'd1, 128'h1f352c073b6108d72d9810a30914dff4);
        read_rk("a256 rk15", 4'd15, 128'h0);

        bus.key_len = 2'd3;
        bus.key     = K128;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        check("rsvd err", 128'(bus.err), 128'd1);
        check("rsvd busy", 128'(bus.busy), 128'd0);
        tick();
        check("rsvd err_pulse", 128'(bus.err), 128'd0);
        check("rsvd busy2", 128'(bus.busy), 128'd0);
        check("rsvd kv", 128'(bus.key_valid), 128'd1);
        bus.rk_idx = 4'd14;
        #1;
        check("rsvd rk14 low", 128'(bus.rk_out[31:0]), 128'h706c631e);

        expand("restart", 2'd0, K128, 40, 10);
        read_rk("restart rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        bus.key_len = 2'd0;
        bus.key     = K128;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (19) tick();
        rst_n = 1'b0;
        #1;
        check("abort busy", 128'(bus.busy), 128'd0);
        check("abort done", 128'(bus.done), 128'd0);
        check("abort kv", 128'(bus.key_valid), 128'd0);
        check("abort err", 128'(bus.err), 128'd0);
        check("abort rk", bus.rk_out, 128'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (bus.done) dones++;
        end
        check("abort no_done", 128'(dones), 128'd0);

        expand("zrun", 2'd0, K128, 40, 0);
        bus.zeroize = 1'b1;
        tick();
        bus.zeroize = 1'b0;
        bus.rk_idx  = 4'd10;
        #1;
`ifdef AES_KEY_ZEROIZE_EN
        check("zero kv", 128'(bus.key_valid), 128'd0);
        check("zero rk", bus.rk_out, 128'h0);
`else
        check("zero kv", 128'(bus.key_valid), 128'd1);
        check("zero rk", bus.rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
